// File: rtl/parser_dma_ctrl.sv
// Descriptor-driven DMA read controller streaming packet words to packet_parser.
// Define PARSER_DMA_LAST_EN to add the pkt_last end-of-packet marker output.
module parser_dma_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 8,
  parameter int DESC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              desc_valid,
  output logic              desc_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
`ifdef PARSER_DMA_LAST_EN
  output logic              pkt_last,
`endif
  output logic              busy,
  output logic              pkt_done,
  output logic [15:0]       pkt_count,
  output logic              err_zero_len
);

  // state | meaning
  // IDLE  | no packet active, waiting for a queued descriptor
  // LOAD  | dequeue head descriptor into cur_addr/remaining
  // FETCH | issue reads while credit allows, counting remaining down
  // DRAIN | all reads issued, waiting for the final word handshake
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, DRAIN} state_t;

  localparam int QP_W = $clog2(DESC_DEPTH);
  localparam logic [QP_W:0]       Q_FULL   = DESC_DEPTH[QP_W:0];
  localparam logic [LEN_W-1:0]    LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE = ADDR_W'(1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] q_addr [DESC_DEPTH];
  logic [LEN_W-1:0]  q_len  [DESC_DEPTH];
  logic [QP_W-1:0]   q_wr, q_rd;
  logic [QP_W:0]     q_cnt, q_cnt_nxt;
  logic              q_push, q_pop;

  logic [WIDTH-1:0]  ob_data [2];
  logic              ob_wr, ob_rd;
  logic [1:0]        ob_cnt;
  logic              rd_inflight;
  logic [2:0]        words_used;
  logic              pop;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;

  assign q_push    = desc_valid && desc_ready;
  assign q_pop     = (state == LOAD);
  assign q_cnt_nxt = q_cnt + {{QP_W{1'b0}}, q_push} - {{QP_W{1'b0}}, q_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr       <= '0;
      q_rd       <= '0;
      q_cnt      <= '0;
      desc_ready <= 1'b0;
    end else begin
      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop)  q_rd <= q_rd + 1'b1;
      q_cnt      <= q_cnt_nxt;
      desc_ready <= (q_cnt_nxt != Q_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr[q_wr] <= desc_addr;
      q_len[q_wr]  <= desc_len;
    end
  end

  // The word returning from memory counts as buffered in its arrival cycle,
  // so it is presented immediately and stored only if not taken.
  assign words_used  = {1'b0, ob_cnt} + {2'b00, rd_inflight};
  assign pkt_valid   = !rst && ((ob_cnt != 2'd0) || rd_inflight);
  assign pkt_data    = (ob_cnt != 2'd0) ? ob_data[ob_rd] :
                       (rd_inflight ? mem_rd_data : '0);
  assign pop         = pkt_valid && pkt_ready;
  assign mem_rd_en   = !rst && (state == FETCH) && (words_used < 3'd2);
  assign mem_rd_addr = cur_addr;
  assign busy        = (state != IDLE) || (q_cnt != '0);

`ifdef PARSER_DMA_LAST_EN
  logic ob_last [2];
  logic rd_last;
  assign pkt_last = pkt_valid && ((ob_cnt != 2'd0) ? ob_last[ob_rd] : rd_last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ob_wr       <= 1'b0;
      ob_rd       <= 1'b0;
      ob_cnt      <= 2'd0;
      rd_inflight <= 1'b0;
`ifdef PARSER_DMA_LAST_EN
      rd_last     <= 1'b0;
`endif
    end else begin
      if (rd_inflight) ob_wr <= ~ob_wr;
      if (pop)         ob_rd <= ~ob_rd;
      ob_cnt      <= ob_cnt + {1'b0, rd_inflight} - {1'b0, pop};
      rd_inflight <= mem_rd_en;
`ifdef PARSER_DMA_LAST_EN
      rd_last     <= mem_rd_en && (remaining == LEN_ONE);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rd_inflight) begin
      ob_data[ob_wr] <= mem_rd_data;
`ifdef PARSER_DMA_LAST_EN
      ob_last[ob_wr] <= rd_last;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    case (state)
      IDLE:  if (q_cnt != '0) state_nxt = LOAD;
      LOAD:  state_nxt = (q_len[q_rd] == '0) ? IDLE : FETCH;
      FETCH: if (mem_rd_en && (remaining == LEN_ONE)) state_nxt = DRAIN;
      DRAIN: begin
        // only this packet's words can be in the pipeline here
        if (pop && (words_used == 3'd1)) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      pkt_count    <= 16'd0;
      err_zero_len <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        cur_addr  <= q_addr[q_rd];
        remaining <= q_len[q_rd];
        if (q_len[q_rd] == '0) err_zero_len <= 1'b1;
      end else if (mem_rd_en) begin
        cur_addr  <= cur_addr + ADDR_ONE;
        remaining <= remaining - LEN_ONE;
      end
      if (pkt_done) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
